// File: rtl/topview_pkg.sv
// Shared types and constants for the top-view segment filter and its output FIFO.
// Segment fields are sized for the default 180 x 480 map.
package topview_pkg;

  localparam int MAP_W = 180;
  localparam int MAP_H = 480;

  localparam logic [3:0] OC_L = 4'b0001;
  localparam logic [3:0] OC_R = 4'b0010;
  localparam logic [3:0] OC_T = 4'b0100;
  localparam logic [3:0] OC_B = 4'b1000;

  function automatic int hw_f(input int w);
    return $clog2(w);
  endfunction

  function automatic int vw_f(input int h);
    return $clog2(h);
  endfunction

  localparam int SEG_HW = hw_f(MAP_W);
  localparam int SEG_VW = vw_f(MAP_H);

  typedef struct packed {
    logic [SEG_VW-1:0] sv;
    logic [SEG_HW-1:0] sh;
    logic [SEG_VW-1:0] ev;
    logic [SEG_HW-1:0] eh;
    logic              marker;
    logic              last;
  } seg_t;

endpackage

// File: rtl/seg_fifo.sv
// First-word-fall-through FIFO of seg_t.
// set_last lets a frame marker that cannot be stored still close the frame on the newest entry.
module seg_fifo import topview_pkg::*; #(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  seg_t        wr_data,
  input  logic        rd_en,
  input  logic        set_last,
  output seg_t        rd_data,
  output logic        empty,
  output logic        full,
  output logic [AW:0] count
);

  seg_t        mem_q [DEPTH];
  seg_t        mem_d [DEPTH];
  logic [AW:0] wp_q, wp_d, rp_q, rp_d, wp_m1;

  assign count   = wp_q - rp_q;
  assign empty   = (wp_q == rp_q);
  assign full    = (count == (AW+1)'(DEPTH));
  assign rd_data = mem_q[rp_q[AW-1:0]];

  always_comb begin
    mem_d = mem_q;
    wp_d  = wp_q;
    rp_d  = rp_q;
    wp_m1 = wp_q - (AW+1)'(1);
    if (wr_en) begin
      mem_d[wp_q[AW-1:0]] = wr_data;
      wp_d                = wp_q + (AW+1)'(1);
    end
    if (set_last) mem_d[wp_m1[AW-1:0]].last = 1'b1;
    if (rd_en && !empty) rp_d = rp_q + (AW+1)'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/topview_seg_filter.sv
// Outcode reject + per-coordinate clamp of top-view segments, queued with frame markers
// for the lane-fitting stage. Two register stages ahead of a FWFT FIFO.
module topview_seg_filter import topview_pkg::*; #(
  parameter  int OUT_WIDTH  = 180,
  parameter  int OUT_HEIGHT = 480,
  parameter  int IN_BITW    = 32,
  parameter  int FIFO_DEPTH = 16,
  parameter  int CNT_BITW   = 16,
  localparam int HW         = hw_f(OUT_WIDTH),
  localparam int VW         = vw_f(OUT_HEIGHT)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic signed [IN_BITW-1:0] in_start_v,
  input  logic signed [IN_BITW-1:0] in_end_v,
  input  logic signed [IN_BITW-1:0] in_start_h,
  input  logic signed [IN_BITW-1:0] in_end_h,
  input  logic                      in_frame_end,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [VW-1:0]             out_start_v,
  output logic [VW-1:0]             out_end_v,
  output logic [HW-1:0]             out_start_h,
  output logic [HW-1:0]             out_end_h,
  output logic                      out_marker,
  output logic                      out_last,
  output logic [CNT_BITW-1:0]       drop_cnt,
  output logic [CNT_BITW-1:0]       reject_cnt
);

  localparam int FAW = $clog2(FIFO_DEPTH);
  localparam logic signed [IN_BITW-1:0] H_MAX = IN_BITW'(OUT_WIDTH - 1);
  localparam logic signed [IN_BITW-1:0] V_MAX = IN_BITW'(OUT_HEIGHT - 1);

  function automatic logic [3:0] outcode(input logic signed [IN_BITW-1:0] v, h);
    logic [3:0] c;
    c = '0;
    if (h[IN_BITW-1]) c |= OC_L;
    if (h > H_MAX)    c |= OC_R;
    if (v[IN_BITW-1]) c |= OC_T;
    if (v > V_MAX)    c |= OC_B;
    return c;
  endfunction

  function automatic logic [HW-1:0] clamp_h(input logic [HW-1:0] x, input logic [3:0] c);
    if (|(c & OC_L)) return '0;
    if (|(c & OC_R)) return HW'(OUT_WIDTH - 1);
    return x;
  endfunction

  function automatic logic [VW-1:0] clamp_v(input logic [VW-1:0] x, input logic [3:0] c);
    if (|(c & OC_T)) return '0;
    if (|(c & OC_B)) return VW'(OUT_HEIGHT - 1);
    return x;
  endfunction

  logic [2:1]          vld_pipe_q, vld_pipe_d, fe_pipe_q, fe_pipe_d;
  logic [VW-1:0]       s1_sv_q, s1_sv_d, s1_ev_q, s1_ev_d;
  logic [HW-1:0]       s1_sh_q, s1_sh_d, s1_eh_q, s1_eh_d;
  logic [3:0]          s1_cs_q, s1_cs_d, s1_ce_q, s1_ce_d;
  logic [VW-1:0]       s2_sv_q, s2_sv_d, s2_ev_q, s2_ev_d;
  logic [HW-1:0]       s2_sh_q, s2_sh_d, s2_eh_q, s2_eh_d;
  logic                s2_out_q, s2_out_d;
  logic [CNT_BITW-1:0] drop_q, drop_d, rej_q, rej_d;

  logic       degen, accept, rejected, push_mark, push, pop, can_wr;
  logic       fifo_wr, set_last, fifo_empty, fifo_full;
  logic [FAW:0] fifo_count;
  seg_t       wr_data, head;

  // Only the low bits are kept in S1: out-of-range values are replaced by the clamp.
  always_comb begin
    vld_pipe_d = {vld_pipe_q[1], in_valid};
    fe_pipe_d  = {fe_pipe_q[1], in_frame_end};
    s1_sv_d    = in_start_v[VW-1:0];
    s1_ev_d    = in_end_v[VW-1:0];
    s1_sh_d    = in_start_h[HW-1:0];
    s1_eh_d    = in_end_h[HW-1:0];
    s1_cs_d    = outcode(in_start_v, in_start_h);
    s1_ce_d    = outcode(in_end_v, in_end_h);
    s2_out_d   = |(s1_cs_q & s1_ce_q);
    s2_sv_d    = clamp_v(s1_sv_q, s1_cs_q);
    s2_ev_d    = clamp_v(s1_ev_q, s1_ce_q);
    s2_sh_d    = clamp_h(s1_sh_q, s1_cs_q);
    s2_eh_d    = clamp_h(s1_eh_q, s1_ce_q);
  end

  always_comb begin
    degen     = (s2_sv_q == s2_ev_q) && (s2_sh_q == s2_eh_q);
    accept    = vld_pipe_q[2] && !s2_out_q && !degen;
    rejected  = vld_pipe_q[2] && !accept;
    push_mark = fe_pipe_q[2] && !accept;
    push      = accept || push_mark;
    pop       = !fifo_empty && out_ready;
    can_wr    = (fifo_count < (FAW+1)'(FIFO_DEPTH)) || pop;
    fifo_wr   = push && can_wr;
    set_last  = push_mark && fifo_full && !pop;
    wr_data   = '0;
    if (accept) begin
      wr_data.sv   = SEG_VW'(s2_sv_q);
      wr_data.ev   = SEG_VW'(s2_ev_q);
      wr_data.sh   = SEG_HW'(s2_sh_q);
      wr_data.eh   = SEG_HW'(s2_eh_q);
      wr_data.last = fe_pipe_q[2];
    end else begin
      wr_data.marker = 1'b1;
      wr_data.last   = 1'b1;
    end
    drop_d = (push && !can_wr && drop_q != '1) ? drop_q + CNT_BITW'(1) : drop_q;
    rej_d  = (rejected && rej_q != '1) ? rej_q + CNT_BITW'(1) : rej_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe_q <= '0;
      fe_pipe_q  <= '0;
      s1_sv_q    <= '0;
      s1_ev_q    <= '0;
      s1_sh_q    <= '0;
      s1_eh_q    <= '0;
      s1_cs_q    <= '0;
      s1_ce_q    <= '0;
      s2_sv_q    <= '0;
      s2_ev_q    <= '0;
      s2_sh_q    <= '0;
      s2_eh_q    <= '0;
      s2_out_q   <= 1'b0;
      drop_q     <= '0;
      rej_q      <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      fe_pipe_q  <= fe_pipe_d;
      s1_sv_q    <= s1_sv_d;
      s1_ev_q    <= s1_ev_d;
      s1_sh_q    <= s1_sh_d;
      s1_eh_q    <= s1_eh_d;
      s1_cs_q    <= s1_cs_d;
      s1_ce_q    <= s1_ce_d;
      s2_sv_q    <= s2_sv_d;
      s2_ev_q    <= s2_ev_d;
      s2_sh_q    <= s2_sh_d;
      s2_eh_q    <= s2_eh_d;
      s2_out_q   <= s2_out_d;
      drop_q     <= drop_d;
      rej_q      <= rej_d;
    end
  end

  seg_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (fifo_wr),
    .wr_data  (wr_data),
    .rd_en    (pop),
    .set_last (set_last),
    .rd_data  (head),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .count    (fifo_count)
  );

  assign out_valid   = !fifo_empty;
  assign out_start_v = fifo_empty ? '0 : VW'(head.sv);
  assign out_end_v   = fifo_empty ? '0 : VW'(head.ev);
  assign out_start_h = fifo_empty ? '0 : HW'(head.sh);
  assign out_end_h   = fifo_empty ? '0 : HW'(head.eh);
  assign out_marker  = !fifo_empty && head.marker;
  assign out_last    = !fifo_empty && head.last;
  assign drop_cnt    = drop_q;
  assign reject_cnt  = rej_q;

endmodule

// File: tb/tb_topview_seg_filter.sv
// Directed bench for topview_seg_filter: latency, clamp/reject, overflow, markers, reset.
module tb_topview_seg_filter;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid, in_frame_end, out_ready;
  logic signed [31:0] in_start_v, in_end_v, in_start_h, in_end_h;
  logic               out_valid, out_marker, out_last;
  logic [8:0]         out_start_v, out_end_v;
  logic [7:0]         out_start_h, out_end_h;
  logic [15:0]        drop_cnt, reject_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  topview_seg_filter dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .in_start_v(in_start_v), .in_end_v(in_end_v),
    .in_start_h(in_start_h), .in_end_h(in_end_h),
    .in_frame_end(in_frame_end), .out_valid(out_valid), .out_ready(out_ready),
    .out_start_v(out_start_v), .out_end_v(out_end_v),
    .out_start_h(out_start_h), .out_end_h(out_end_h),
    .out_marker(out_marker), .out_last(out_last),
    .drop_cnt(drop_cnt), .reject_cnt(reject_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Drives one cycle starting at a negedge; returns at the next negedge.
  task automatic seg(input int sv, input int ev, input int sh, input int eh, input logic fe);
    in_valid = 1'b1; in_frame_end = fe;
    in_start_v = sv; in_end_v = ev; in_start_h = sh; in_end_h = eh;
    @(negedge clk);
    in_valid = 1'b0; in_frame_end = 1'b0;
  endtask

  task automatic frame_end_only();
    in_frame_end = 1'b1;
    @(negedge clk);
    in_frame_end = 1'b0;
  endtask

  task automatic check_head(input string tag, input int sv, input int ev, input int sh,
                            input int eh, input logic mk, input logic lst);
    check({tag, ".vld"}, out_valid, 1);
    check({tag, ".sv"}, out_start_v, sv);
    check({tag, ".ev"}, out_end_v, ev);
    check({tag, ".sh"}, out_start_h, sh);
    check({tag, ".eh"}, out_end_h, eh);
    check({tag, ".mk"}, out_marker, mk);
    check({tag, ".last"}, out_last, lst);
  endtask

  task automatic wait_out(input string tag, input int sv, input int ev, input int sh,
                          input int eh, input logic mk, input logic lst);
    int n = 0;
    while (!out_valid && n < 10) begin @(negedge clk); n++; end
    check_head(tag, sv, ev, sh, eh, mk, lst);
    @(negedge clk);
  endtask

  task automatic expect_none(input string tag, input int cycles);
    int seen = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check(tag, seen, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_frame_end = 1'b0; out_ready = 1'b1;
    in_start_v = 0; in_end_v = 0; in_start_h = 0; in_end_h = 0;
    repeat (3) @(negedge clk);
    check("rst.vld", out_valid, 0);
    check("rst.sv", out_start_v, 0);
    check("rst.last", out_last, 0);
    check("rst.drop", drop_cnt, 0);
    check("rst.rej", reject_cnt, 0);
    rst = 1'b0;
    @(negedge clk);

    // Latency: valid at t, out_valid first seen at t+3.
    seg(10, 400, 20, 150, 1'b0);
    check("lat.t1", out_valid, 0);
    @(negedge clk);
    check("lat.t2", out_valid, 0);
    @(negedge clk);
    check_head("lat.t3", 10, 400, 20, 150, 1'b0, 1'b0);
    check("lat.drop", drop_cnt, 0);
    check("lat.rej", reject_cnt, 0);
    @(negedge clk);
    check("lat.popped", out_valid, 0);

    seg(100, 300, -50, 200, 1'b0);
    wait_out("clamp", 100, 300, 0, 179, 1'b0, 1'b0);

    seg(50, 60, -5, -90, 1'b0);
    expect_none("rejL.none", 6);
    check("rejL.cnt", reject_cnt, 1);

    seg(500, 600, 300, 400, 1'b0);
    expect_none("rejBR.none", 6);
    check("rejBR.cnt", reject_cnt, 2);

    seg(480, 490, 179, 179, 1'b0);
    expect_none("rejB.none", 6);
    check("rejB.cnt", reject_cnt, 3);

    // Clamps to the same point (h -3 -> 0, h 0) -> degenerate.
    seg(50, 50, -3, 0, 1'b0);
    expect_none("degen.none", 6);
    check("degen.cnt", reject_cnt, 4);

    // Overflow: 20 back-to-back with consumer stalled.
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++) seg(i + 1, i + 200, i, i + 100, 1'b0);
    repeat (4) @(negedge clk);
    check("ovf.drop", drop_cnt, 4);
    check("ovf.vld", out_valid, 1);
    check("ovf.hold", out_start_v, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("drain%0d.vld", i), out_valid, 1);
      check($sformatf("drain%0d.sv", i), out_start_v, i + 1);
      check($sformatf("drain%0d.eh", i), out_end_h, i + 100);
      @(negedge clk);
    end
    check("drain.empty", out_valid, 0);

    frame_end_only();
    wait_out("mark", 0, 0, 0, 0, 1'b1, 1'b1);
    expect_none("mark.one", 4);

    seg(50, 60, -5, -90, 1'b1);
    wait_out("rejmark", 0, 0, 0, 0, 1'b1, 1'b1);
    expect_none("rejmark.one", 5);
    check("rejmark.cnt", reject_cnt, 5);

    seg(30, 60, 40, 70, 1'b1);
    wait_out("acclast", 30, 60, 40, 70, 1'b0, 1'b1);
    expect_none("acclast.one", 5);

    // Marker against a full FIFO closes the frame on the newest entry.
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) seg(i + 1, i + 200, i, i + 100, 1'b0);
    frame_end_only();
    repeat (4) @(negedge clk);
    check("fullmark.drop", drop_cnt, 5);
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("fm%0d.sv", i), out_start_v, i + 1);
      check($sformatf("fm%0d.last", i), out_last, (i == 15) ? 1 : 0);
      check($sformatf("fm%0d.mk", i), out_marker, 0);
      @(negedge clk);
    end
    check("fullmark.empty", out_valid, 0);

    // Reset with 5 queued and 2 in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) seg(i + 1, i + 200, i, i + 100, 1'b0);
    check("mid.queued", out_valid, 1);
    rst = 1'b1;
    #1;
    check("mid.vld", out_valid, 0);
    check("mid.drop", drop_cnt, 0);
    check("mid.rej", reject_cnt, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    expect_none("mid.stale", 8);
    check("mid.drop2", drop_cnt, 0);
    check("mid.rej2", reject_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
